// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 set-2 key tracker.
// KEY_TABLE entries are {ext bit, scancode}.
package ps2_key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // left, down, right, up, insert, delete, home, end
  localparam logic [8:0] KEY_TABLE [8] = '{
    9'h16B, 9'h172, 9'h174, 9'h175, 9'h170, 9'h171, 9'h16C, 9'h169
  };

endpackage

// File: rtl/ps2_key_match.sv
// Combinational {ext, code} to one-hot matcher over the first NUM_KEYS table entries.
module ps2_key_match
  import ps2_key_pkg::*;
#(
  parameter int NUM_KEYS = 4
) (
  input  logic                ext,
  input  logic [7:0]          code,
  output logic [NUM_KEYS-1:0] hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit[i] = ({ext, code} == KEY_TABLE[i]);
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode follower: E0/F0 prefix FSM, per-key held state, make/break pulses
// and a timeout that abandons prefix sequences left hanging.
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                areset,
  input  logic [7:0]          in_byte,
  input  logic                in_valid,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] make_pulse,
  output logic [NUM_KEYS-1:0] break_pulse,
  output logic                timeout
);

  localparam int CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  ps2_state_t          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;
  logic [NUM_KEYS-1:0] make_q, make_d;
  logic [NUM_KEYS-1:0] break_q, break_d;
  logic                timeout_q, timeout_d;

  logic                lookup_ext;
  logic                do_make;
  logic                do_break;
  logic [NUM_KEYS-1:0] hit;

  ps2_key_match #(
    .NUM_KEYS(NUM_KEYS)
  ) u_match (
    .ext (lookup_ext),
    .code(in_byte),
    .hit (hit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lookup_ext = 1'b0;
    do_make    = 1'b0;
    do_break   = 1'b0;
    timeout_d  = 1'b0;

    if (in_valid) begin
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (in_byte == PS2_EXT) begin
            state_d = EXT;
          end else if (in_byte == PS2_BRK) begin
            state_d = BRK;
          end else begin
            do_make = 1'b1;
          end
        end
        EXT: begin
          if (in_byte == PS2_BRK) begin
            state_d = EXT_BRK;
          end else if (in_byte == PS2_EXT) begin
            state_d = EXT;
          end else begin
            lookup_ext = 1'b1;
            do_make    = 1'b1;
            state_d    = IDLE;
          end
        end
        BRK: begin
          do_break = 1'b1;
          state_d  = IDLE;
        end
        EXT_BRK: begin
          lookup_ext = 1'b1;
          do_break   = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // Expire on the idle cycle that would bring the count up to TIMEOUT_CYCLES.
      if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1))) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
        cnt_d     = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    key_down_d = key_down_q;
    make_d     = '0;
    break_d    = '0;
    if (do_make) begin
      make_d     = hit & ~key_down_q;
      key_down_d = key_down_q | hit;
    end
    if (do_break) begin
      break_d    = hit & key_down_q;
      key_down_d = key_down_q & ~hit;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_down_q <= '0;
      make_q     <= '0;
      break_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_down_q <= key_down_d;
      make_q     <= make_d;
      break_q    <= break_d;
      timeout_q  <= timeout_d;
    end
  end

  assign key_down    = key_down_q;
  assign make_pulse  = make_q;
  assign break_pulse = break_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench: stimulus queues hand-computed events with their due cycle; a monitor
// checks two DUTs (8 keys and 4 keys, 8-cycle timeout) against the queue every cycle.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;

  logic [7:0] kd8, mk8, bk8;
  logic       to8;
  logic [3:0] kd4, mk4, bk4;
  logic       to4;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .NUM_KEYS      (8),
    .TIMEOUT_CYCLES(8)
  ) dut8 (
    .clk        (clk),
    .areset     (areset),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .key_down   (kd8),
    .make_pulse (mk8),
    .break_pulse(bk8),
    .timeout    (to8)
  );

  ps2_key_tracker #(
    .NUM_KEYS      (4),
    .TIMEOUT_CYCLES(8)
  ) dut4 (
    .clk        (clk),
    .areset     (areset),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .key_down   (kd4),
    .make_pulse (mk4),
    .break_pulse(bk4),
    .timeout    (to4)
  );

  typedef struct {
    int         cyc;
    logic [7:0] mk;
    logic [7:0] bk;
    logic       to;
    logic [7:0] kd;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  bit         started = 1'b0;
  logic [7:0] exp_kd = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (areset) begin
      exp_kd = 8'h00;
    end else if (started) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_event cyc=%0d due=%0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
      end else begin
        e.cyc = cyc;
        e.mk  = 8'h00;
        e.bk  = 8'h00;
        e.to  = 1'b0;
        e.kd  = exp_kd;
      end
      exp_kd = e.kd;
      tests++;
      if ({kd8, mk8, bk8, to8} !== {e.kd, e.mk, e.bk, e.to}) begin
        fails++;
        $display("FAIL dut8 cyc=%0d got kd=%h mk=%h bk=%h to=%b want kd=%h mk=%h bk=%h to=%b",
                 cyc, kd8, mk8, bk8, to8, e.kd, e.mk, e.bk, e.to);
      end
      tests++;
      if ({kd4, mk4, bk4, to4} !== {e.kd[3:0], e.mk[3:0], e.bk[3:0], e.to}) begin
        fails++;
        $display("FAIL dut4 cyc=%0d got kd=%h mk=%h bk=%h to=%b want kd=%h mk=%h bk=%h to=%b",
                 cyc, kd4, mk4, bk4, to4, e.kd[3:0], e.mk[3:0], e.bk[3:0], e.to);
      end
    end
  end

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Expect an event d cycles after the current one (d=1 for a byte just driven).
  task automatic expect_ev(input int d, input logic [7:0] mk, input logic [7:0] bk,
                           input logic to, input logic [7:0] kd);
    ev_t e;
    e.cyc = cyc + d;
    e.mk  = mk;
    e.bk  = bk;
    e.to  = to;
    e.kd  = kd;
    q.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({kd8, mk8, bk8, to8, kd4, mk4, bk4, to4} !== '0) begin
      fails++;
      $display("FAIL %s got kd8=%h mk8=%h bk8=%h to8=%b kd4=%h mk4=%h bk4=%h to4=%b want all 0",
               name, kd8, mk8, bk8, to8, kd4, mk4, bk4, to4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    @(negedge clk);
    areset = 1'b0;
    check_all_zero("reset_state");
    started = 1'b1;
    idle(2);

    // up make then extended break
    drive(8'hE0); drive(8'h75); expect_ev(1, 8'h08, 8'h00, 1'b0, 8'h08);
    idle(2);
    drive(8'hE0); drive(8'hF0); drive(8'h75); expect_ev(1, 8'h00, 8'h08, 1'b0, 8'h00);
    idle(2);

    // typematic repeat of left pulses once
    drive(8'hE0); drive(8'h6B); expect_ev(1, 8'h01, 8'h00, 1'b0, 8'h01);
    idle(1);
    drive(8'hE0); drive(8'h6B);
    idle(1);
    drive(8'hE0); drive(8'h6B);
    idle(2);
    drive(8'hE0); drive(8'hF0); drive(8'h6B); expect_ev(1, 8'h00, 8'h01, 1'b0, 8'h00);
    idle(2);

    // non-extended and unlisted codes do nothing
    drive(8'h6B);
    drive(8'hF0); drive(8'h6B);
    drive(8'hE0); drive(8'h1C);
    idle(3);

    // insert exists only in the 8-key build
    drive(8'hE0); drive(8'h70); expect_ev(1, 8'h10, 8'h00, 1'b0, 8'h10);
    idle(2);
    drive(8'hE0); drive(8'hF0); drive(8'h70); expect_ev(1, 8'h00, 8'h10, 1'b0, 8'h00);
    idle(2);

    // timeout 9 cycles after a lone E0; following 75 is a non-extended no-match
    drive(8'hE0); expect_ev(9, 8'h00, 8'h00, 1'b1, 8'h00);
    idle(8);
    drive(8'h75);
    idle(3);

    // byte on the would-be expiry cycle wins
    drive(8'hE0);
    idle(7);
    drive(8'h75); expect_ev(1, 8'h08, 8'h00, 1'b0, 8'h08);
    idle(2);
    drive(8'hE0); drive(8'hF0); drive(8'h75); expect_ev(1, 8'h00, 8'h08, 1'b0, 8'h00);
    idle(2);

    // hold left and up, then reset between E0 and F0
    drive(8'hE0); drive(8'h6B); expect_ev(1, 8'h01, 8'h00, 1'b0, 8'h01);
    drive(8'hE0); drive(8'h75); expect_ev(1, 8'h08, 8'h00, 1'b0, 8'h09);
    idle(2);
    drive(8'hE0);
    @(posedge clk);
    #2;
    areset   = 1'b1;
    in_valid = 1'b0;
    #1;
    check_all_zero("async_reset_mid_sequence");
    idle(2);
    @(negedge clk);
    areset = 1'b0;
    drive(8'hF0); drive(8'h75);
    idle(12);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_events got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Stateful PS/2 set-2 scancode decoder that follows a received byte stream. It handles the E0 (extended) and F0 (break) prefixes and keeps a held/released bit per tracked key. It also emits single-cycle make/break event pulses and recovers from truncated prefix sequences with a timeout. It sits between the PS/2 byte receiver and game/UI control logic, and is the generalised, sequential successor to the combinational arrow-key decoder.

## Interface
- `NUM_KEYS`, default 4: number of tracked keys, legal range 1..8. Uses entries 0..NUM_KEYS-1 of `KEY_TABLE`.
- `TIMEOUT_CYCLES`, default 1024: idle cycles allowed inside a prefix sequence. 0 disables the timeout.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `areset`, in, 1: asynchronous reset, active-high.
- `in_byte`, in, 8: received scancode byte.
- `in_valid`, in, 1: `in_byte` is valid this cycle. At most one byte per cycle; there is no backpressure and the block always accepts.
- `key_down`, out, NUM_KEYS: held state per key. Bit i is `KEY_TABLE[i]`.
- `make_pulse`, out, NUM_KEYS: one-cycle pulse when key i transitions released→held.
- `break_pulse`, out, NUM_KEYS: one-cycle pulse when key i transitions held→released.
- `timeout`, out, 1: one-cycle pulse when a prefix sequence is abandoned.

## Operation
- Reset values: `key_down`=0, `make_pulse`=0, `break_pulse`=0, `timeout`=0, state=IDLE, timeout counter=0.
- The FSM has four states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). The state changes only on cycles where `in_valid`=1, except for the timeout.
- Transitions from IDLE:
  - E0→EXT.
  - F0→BRK.
  - Any other byte is a non-extended make; stay in IDLE.
- Transitions from EXT:
  - F0→EXT_BRK.
  - E0→EXT (repeated prefix, tolerated).
  - Any other byte is an extended make; go to IDLE.
- Transitions from BRK: any byte is a non-extended break code; go to IDLE. E0 or F0 here match no table entry.
- Transitions from EXT_BRK: any byte is an extended break code; go to IDLE.
- Lookup: key i matches when `{ext, code}` equals `KEY_TABLE[i]`. A code with no match updates nothing and produces no pulse.
- Make on key i:
  - If the key was released: set `key_down[i]` and pulse `make_pulse[i]`.
  - If it was already held (typematic repeat): no change and no pulse.
- Break on key i:
  - If the key was held: clear `key_down[i]` and pulse `break_pulse[i]`.
  - If it was already released: no change and no pulse.
- Timeout counter:
  - Cleared on every accepted byte.
  - Increments each cycle the state is not IDLE and `in_valid`=0.
  - When it reaches `TIMEOUT_CYCLES`: state goes to IDLE, `timeout` pulses, the counter clears, and `key_down` is unchanged.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.
- Reset asserted mid-sequence immediately forces all reset values, including clearing any held keys.

## Timing
- All outputs are registered.
- A byte accepted in cycle T shows its `key_down` change and any pulse in cycle T+1. Pulses are exactly one cycle wide.
- Back-to-back bytes on consecutive cycles are fully supported, e.g. E0, 75 in cycles T and T+1 gives `make_pulse` in T+2.
- A prefix accepted in cycle T with no further valid byte through T+`TIMEOUT_CYCLES` gives `timeout`=1 and state=IDLE in cycle T+`TIMEOUT_CYCLES`+1.
- If `in_valid` arrives in the same cycle the count would expire, the byte wins: it is decoded normally and no timeout occurs.

## Structure
- Package `ps2_key_pkg` holds:
  - The state enum `ps2_state_t` (IDLE, EXT, BRK, EXT_BRK).
  - `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0.
  - The 8-entry `KEY_TABLE` of {ext bit, code}:
    - 0: left E0 6B
    - 1: down E0 72
    - 2: right E0 74
    - 3: up E0 75
    - 4: insert E0 70
    - 5: delete E0 71
    - 6: home E0 6C
    - 7: end E0 69
- One sub-module, `ps2_key_match`: a combinational `{ext, code}` to one-hot NUM_KEYS matcher. The FSM, counter and key registers live in the top module.

## Test plan
- Reset, then E0 75 → cycle after 75: `key_down`=4'b1000, `make_pulse`=4'b1000 for one cycle. Then E0 F0 75 → `key_down`=0, `break_pulse`=4'b1000 for one cycle.
- E0 6B, E0 6B, E0 6B (typematic) → `make_pulse[0]` pulses once only and `key_down[0]` stays 1. Then E0 F0 6B → one `break_pulse[0]`.
- Unlisted and non-extended codes: 6B alone, F0 6B, and E0 1C → no output change. With `NUM_KEYS`=4, E0 70 → no output change. With `NUM_KEYS`=8, E0 70 → `make_pulse[4]`.
- `TIMEOUT_CYCLES`=8:
  - E0, then 8 idle cycles → `timeout` pulses 9 cycles after E0.
  - Following 75 → non-extended lookup, no match, no pulse.
  - E0 with 75 on exactly the 8th idle cycle → `make_pulse[3]`, no timeout.
- Hold left and up, then assert `areset` between E0 and F0 → all outputs 0 immediately. A later F0 75 after reset produces no pulse.
